// File: rtl/pipeline_pkg.sv
// Shared constants and width helpers for the generated pipeline and its credit collector.
package pipeline_pkg;

    localparam int unsigned LATENCY = 32'd3;

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 32'd1);
    endfunction

    // A single-entry buffer still needs a one-bit pointer.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 32'd1) ? $clog2(depth) : 32'd1;
    endfunction

endpackage

// File: rtl/pipeline_result_fifo.sv
// First-word fall-through result buffer with explicit pointer wrap and a sticky overflow flag.
module pipeline_result_fifo
    import pipeline_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] head_data_o,
    output logic                  not_empty_o,
    output logic                  overflow_o
);

    localparam int unsigned PTR_W = ptr_width(DEPTH);
    localparam int unsigned CNT_W = cnt_width(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 32'd1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wptr_q, wptr_d;
    logic [PTR_W-1:0]      rptr_q, rptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  full_s, pop_s, write_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? {PTR_W{1'b0}} : ptr + PTR_W'(1);
    endfunction

    always_comb begin
        full_s     = (count_q == FULL_CNT);
        pop_s      = pop_i && (count_q != {CNT_W{1'b0}});
        // A push into a full buffer only lands when the head leaves in the same cycle.
        write_s    = push_i && (!full_s || pop_s);
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (write_s) begin
            wptr_d = ptr_inc(wptr_q);
        end else begin
            wptr_d = wptr_q;
        end
        if (pop_s) begin
            rptr_d = ptr_inc(rptr_q);
        end else begin
            rptr_d = rptr_q;
        end
        case ({write_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (push_i && full_s && !pop_s) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q     <= {PTR_W{1'b0}};
            rptr_q     <= {PTR_W{1'b0}};
            count_q    <= {CNT_W{1'b0}};
            overflow_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is deliberately left unreset; the head is only meaningful while not empty.
    always_ff @(posedge clk_i) begin
        if (write_s) begin
            mem_q[wptr_q] <= push_data_i;
        end
    end

    assign head_data_o = mem_q[rptr_q];
    assign not_empty_o = (count_q != {CNT_W{1'b0}});
    assign overflow_o  = overflow_q;

endmodule

// File: rtl/pipeline_credit_collector.sv
// Terminates a valid-only fixed-latency pipeline: issues only against a reserved buffer slot,
// buffers results and hands them to a stalling consumer over ready/valid.
module pipeline_credit_collector
    import pipeline_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LATENCY    = pipeline_pkg::LATENCY,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  pipe_input_valid,
    input  logic [DATA_WIDTH-1:0] pipe_out,
    input  logic                  pipe_output_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  overflow
);

    localparam int unsigned CNT_W = cnt_width(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    if (DEPTH < 32'd1 || LATENCY < 32'd1) begin : g_bad_cfg
        $error("pipeline_credit_collector: DEPTH and LATENCY must both be at least 1");
    end

    logic [CNT_W-1:0] reserved_q, reserved_d;
    logic             issue_s, pop_s;

    // Credit depends on the register alone so out_ready never reaches in_ready combinationally.
    assign in_ready         = (reserved_q < FULL_CNT);
    assign issue_s          = in_valid && in_ready;
    assign pipe_input_valid = issue_s;
    assign pop_s            = out_valid && out_ready;

    always_comb begin
        reserved_d = reserved_q;
        case ({issue_s, pop_s})
            2'b10:   reserved_d = reserved_q + CNT_W'(1);
            2'b01:   reserved_d = reserved_q - CNT_W'(1);
            default: reserved_d = reserved_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reserved_q <= {CNT_W{1'b0}};
        end else begin
            reserved_q <= reserved_d;
        end
    end

    pipeline_result_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk_i       (clk),
        .rst_i       (rst),
        .push_i      (pipe_output_valid),
        .push_data_i (pipe_out),
        .pop_i       (pop_s),
        .head_data_o (out_data),
        .not_empty_o (out_valid),
        .overflow_o  (overflow)
    );

endmodule
